// File: rtl/imm_field_encoder.sv
// imm_field_encoder: packs a 64-bit immediate into the 26-bit instruction
// immediate field for the selected format, reports whether the value fits
// exactly, and counts inputs that did not fit. The datapath is a two-stage
// valid/ready pipeline with full throughput.
module imm_field_encoder #(
  parameter int ERR_W = 16
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_imm,
  input  logic [2:0]       in_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [25:0]      out_imm26,
  output logic [2:0]       out_ctrl,
  output logic             out_fit,
  input  logic             err_clr,
  output logic [ERR_W-1:0] err_count
);

  // Stage 1 keeps only the low 26 bits of the immediate; every format packs
  // from bits at or below bit 25, so the upper bits matter only for fit.
  logic        s1_valid;
  logic [25:0] s1_imm;
  logic [2:0]  s1_ctrl;
  logic        s1_fit;

  logic        s2_valid;
  logic [25:0] s2_field;
  logic [2:0]  s2_ctrl;
  logic        s2_fit;

  logic        s1_load;
  logic        s2_load;
  logic        accept;
  logic        in_fit;
  logic [25:0] packed_field;

  // A stage may load when it is empty or its contents leave this cycle.
  assign s2_load  = ~s2_valid | out_ready;
  assign s1_load  = ~s1_valid | s2_load;
  assign in_ready = s1_load;
  assign accept   = in_valid & in_ready;

  assign out_valid = s2_valid;
  assign out_imm26 = s2_field;
  assign out_ctrl  = s2_ctrl;
  assign out_fit   = s2_fit;

  // Representability check: unsigned formats need zero upper bits, signed
  // formats need all bits above the sign bit to match the sign bit.
  always_comb begin
    in_fit = 1'b0;
    case (in_ctrl)
      3'b000:  in_fit = ~|in_imm[63:12];
      3'b001:  in_fit = (&in_imm[63:8])  | ~|in_imm[63:8];
      3'b010:  in_fit = (&in_imm[63:25]) | ~|in_imm[63:25];
      3'b011:  in_fit = (&in_imm[63:18]) | ~|in_imm[63:18];
      default: in_fit = ~|in_imm[63:16];
    endcase
  end

  // Place the truncated low bits of the stage-1 immediate into the field
  // position used by its format; every other bit stays zero.
  always_comb begin
    packed_field = '0;
    case (s1_ctrl)
      3'b000:  packed_field[21:10] = s1_imm[11:0];
      3'b001:  packed_field[20:12] = s1_imm[8:0];
      3'b010:  packed_field[25:0]  = s1_imm[25:0];
      3'b011:  packed_field[23:5]  = s1_imm[18:0];
      default: packed_field[20:5]  = s1_imm[15:0];
    endcase
  end

  // Stage 1 register: captures the accepted immediate, format and fit flag.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      s1_valid <= 1'b0;
      s1_imm   <= '0;
      s1_ctrl  <= '0;
      s1_fit   <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      s1_imm   <= in_imm[25:0];
      s1_ctrl  <= in_ctrl;
      s1_fit   <= in_fit;
    end
  end

  // Stage 2 register: holds the packed result presented on the outputs and
  // keeps it frozen while downstream stalls.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      s2_valid <= 1'b0;
      s2_field <= '0;
      s2_ctrl  <= '0;
      s2_fit   <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      s2_field <= packed_field;
      s2_ctrl  <= s1_ctrl;
      s2_fit   <= s1_fit;
    end
  end

  // Saturating count of accepted inputs that did not fit; clear wins.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (accept && !in_fit && (err_count != '1)) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_field_encoder.sv
// tb_imm_field_encoder: randomized and directed stimulus with a queue-based
// scoreboard; a monitor retires outputs against an arithmetic reference model
// and reconstructs the immediate through a behavioural sign extender.
module tb_imm_field_encoder;

  localparam int ERR_W = 16;

  logic             CLK = 1'b0;
  logic             Reset_L = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [63:0]      in_imm = '0;
  logic [2:0]       in_ctrl = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [25:0]      out_imm26;
  logic [2:0]       out_ctrl;
  logic             out_fit;
  logic             err_clr = 1'b0;
  logic [ERR_W-1:0] err_count;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  ctrl;
    logic [25:0] field;
    logic        fit;
  } exp_t;

  exp_t sb[$];
  int   nVectors = 0;
  int   nMiscompares = 0;
  int   errModel = 0;
  int   occ = 0;
  int   readyMode = 0;

  imm_field_encoder #(.ERR_W(ERR_W)) dut (
    .CLK(CLK), .Reset_L(Reset_L),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm26(out_imm26), .out_ctrl(out_ctrl), .out_fit(out_fit),
    .err_clr(err_clr), .err_count(err_count)
  );

  always #5 CLK = ~CLK;

  // Reference: fit from numeric range, field from modular arithmetic.
  function automatic exp_t model(input logic [63:0] imm, input logic [2:0] ctrl);
    exp_t   m;
    longint s;
    int     w;
    int     sh;
    logic [63:0] low;
    s = $signed(imm);
    case (ctrl)
      3'd0:    begin w = 12; sh = 10; m.fit = (imm < 64'd4096); end
      3'd1:    begin w = 9;  sh = 12; m.fit = (s >= -256 && s <= 255); end
      3'd2:    begin w = 26; sh = 0;  m.fit = (s >= -33554432 && s <= 33554431); end
      3'd3:    begin w = 19; sh = 5;  m.fit = (s >= -262144 && s <= 262143); end
      default: begin w = 16; sh = 5;  m.fit = (imm < 64'd65536); end
    endcase
    low     = imm % (64'd1 << w);
    m.field = 26'(low * (64'd1 << sh));
    m.imm   = imm;
    m.ctrl  = ctrl;
    return m;
  endfunction

  // Behavioural model of the pipeline's immediate sign extender.
  function automatic logic [63:0] sext(input logic [25:0] f, input logic [2:0] c);
    longint t;
    longint fv;
    fv = longint'(f);
    case (c)
      3'd0:    t = (fv / 1024) % 4096;
      3'd1:    begin t = (fv / 4096) % 512;  if (t >= 256) t = t - 512; end
      3'd2:    begin t = fv;                  if (t >= 33554432) t = t - 67108864; end
      3'd3:    begin t = (fv / 32) % 524288; if (t >= 262144) t = t - 524288; end
      default: t = (fv / 32) % 65536;
    endcase
    return 64'(t);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one transaction and record its expected result at acceptance.
  task automatic applyStimulus(input logic [63:0] imm, input logic [2:0] ctrl);
    exp_t e;
    bit   done;
    e = model(imm, ctrl);
    done = 0;
    in_imm = imm;
    in_ctrl = ctrl;
    in_valid = 1'b1;
    for (int t = 0; t < 1000 && !done; t++) begin
      if (in_ready) begin
        sb.push_back(e);
        if (err_clr) errModel = 0;
        else if (!e.fit && errModel != 65535) errModel++;
        done = 1;
      end
      @(negedge CLK);
    end
    in_valid = 1'b0;
    if (!done) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    readyMode = 0;
    for (int i = 0; i < 200 && (sb.size() != 0 || out_valid); i++) @(negedge CLK);
    checkOutput("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // out_ready pattern, changed shortly after each rising edge.
  initial begin
    forever begin
      @(posedge CLK);
      #2;
      case (readyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        2:       out_ready = 1'($urandom_range(1, 0));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Count transactions resident in the pipeline.
  always @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) occ <= 0;
    else occ <= occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
  end

  // Monitor: retires outputs against the scoreboard and checks stall hold.
  initial begin
    logic        held;
    logic [25:0] heldImm;
    logic [2:0]  heldCtrl;
    logic        heldFit;
    exp_t        e;
    held = 0;
    heldImm = '0;
    heldCtrl = '0;
    heldFit = 0;
    forever begin
      @(negedge CLK);
      if (!Reset_L) begin
        held = 0;
      end else begin
        checkOutput("in_ready", 64'(in_ready), 64'(!(occ == 2 && !out_ready)));
        if (held) begin
          checkOutput("hold_valid", 64'(out_valid), 64'd1);
          checkOutput("hold_imm26", 64'(out_imm26), 64'(heldImm));
          checkOutput("hold_ctrl", 64'(out_ctrl), 64'(heldCtrl));
          checkOutput("hold_fit", 64'(out_fit), 64'(heldFit));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_output", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            checkOutput("imm26", 64'(out_imm26), 64'(e.field));
            checkOutput("ctrl", 64'(out_ctrl), 64'(e.ctrl));
            checkOutput("fit", 64'(out_fit), 64'(e.fit));
            if (e.fit) checkOutput("roundtrip", sext(out_imm26, out_ctrl), e.imm);
          end
        end
        held = out_valid && !out_ready;
        heldImm = out_imm26;
        heldCtrl = out_ctrl;
        heldFit = out_fit;
      end
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
    logic [63:0] r;
    logic [2:0]  c;

    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_imm26", 64'(out_imm26), 64'd0);
    checkOutput("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    checkOutput("rst_out_fit", 64'(out_fit), 64'd0);
    checkOutput("rst_err_count", 64'(err_count), 64'd0);
    @(negedge CLK);
    Reset_L = 1'b1;
    @(negedge CLK);

    $display("[TB] directed formats and latency");
    applyStimulus(64'hABC, 3'd0);
    checkOutput("latency_n1", 64'(out_valid), 64'd0);
    @(negedge CLK);
    checkOutput("latency_n2", 64'(out_valid), 64'd1);
    checkOutput("latency_imm26", 64'(out_imm26), 64'h2AF000);
    applyStimulus(64'h1000, 3'd0);
    drain();
    checkOutput("err_count_1", 64'(err_count), 64'd1);
    applyStimulus(64'hFFFF_FFFF_FFFF_FF00, 3'd1);
    applyStimulus(64'd256, 3'd1);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 3'd3);
    applyStimulus(64'h200_0000, 3'd2);
    applyStimulus(64'hFFFF, 3'd4);
    applyStimulus(64'h1_0000, 3'd7);
    drain();
    checkOutput("err_count_dir", 64'(err_count), 64'(errModel));

    $display("[TB] back-to-back with toggling out_ready");
    readyMode = 1;
    for (int i = 0; i < 8; i++) applyStimulus(64'(i * 1000), 3'(i % 5));
    drain();

    $display("[TB] err_clr coincident with a non-fitting accept");
    err_clr = 1'b1;
    applyStimulus(64'h1000, 3'd0);
    err_clr = 1'b0;
    checkOutput("err_clr_prio", 64'(err_count), 64'd0);
    drain();

    $display("[TB] randomized stream");
    readyMode = 2;
    for (int i = 0; i < 10000; i++) begin
      r = {$urandom, $urandom};
      if ($urandom_range(1, 0) == 1) r = $signed(r) >>> $urandom_range(63, 0);
      else r = r >> $urandom_range(63, 0);
      c = 3'($urandom_range(7, 0));
      applyStimulus(r, c);
    end
    drain();
    checkOutput("err_count_rand", 64'(err_count), 64'(errModel));

    $display("[TB] asynchronous reset with both stages full");
    readyMode = 3;
    @(negedge CLK);
    @(negedge CLK);
    applyStimulus(64'h1234, 3'd2);
    applyStimulus(64'h5678, 3'd4);
    checkOutput("full_out_valid", 64'(out_valid), 64'd1);
    #3;
    Reset_L = 1'b0;
    #1;
    checkOutput("arst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("arst_err_count", 64'(err_count), 64'd0);
    checkOutput("arst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    errModel = 0;
    readyMode = 0;
    @(negedge CLK);
    Reset_L = 1'b1;
    @(negedge CLK);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFF0, 3'd3);
    applyStimulus(64'h7FF, 3'd1);
    drain();
    checkOutput("err_count_post", 64'(err_count), 64'(errModel));

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
